// File: rtl/div_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq_ctrl_pkg
//  Description : Shared definitions for the sequential divider controller:
//                controller state encoding, register-file indices, ALU
//                function codes and write-data source codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_seq_ctrl_pkg;

    localparam int C_DATA_W = 32;
    localparam int C_ADDR_W = 4;
    localparam int C_FUNC_W = 4;

    // Controller states. Encoded explicitly so the state register width is
    // fixed and unused codes are well defined (they decode as IDLE).
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LDA  = 4'd1,
        S_LDB  = 4'd2,
        S_CLRQ = 4'd3,
        S_LD1  = 4'd4,
        S_CHKZ = 4'd5,
        S_CMP  = 4'd6,
        S_SUBT = 4'd7,
        S_INCQ = 4'd8,
        S_FIN  = 4'd9
    } state_t;

    // Register-file map
    localparam logic [C_ADDR_W-1:0] C_R0 = 4'd0; // hard zero
    localparam logic [C_ADDR_W-1:0] C_R1 = 4'd1; // dividend / remainder
    localparam logic [C_ADDR_W-1:0] C_R2 = 4'd2; // divisor
    localparam logic [C_ADDR_W-1:0] C_R3 = 4'd3; // quotient
    localparam logic [C_ADDR_W-1:0] C_R4 = 4'd4; // constant one

    // ALU function codes
    localparam logic [C_FUNC_W-1:0] C_FUNC_ADD  = 4'd0;
    localparam logic [C_FUNC_W-1:0] C_FUNC_SUB  = 4'd1;
    localparam logic [C_FUNC_W-1:0] C_FUNC_PASS = 4'd2;

    // Write-data source select
    localparam logic C_WDSRC_CONST = 1'b0;
    localparam logic C_WDSRC_ALU   = 1'b1;

endpackage : div_seq_ctrl_pkg
`default_nettype wire

// File: rtl/div_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq_ctrl_if
//  Description : Bundle between the divider controller and its environment
//                (requester + register-file/ALU datapath).
//                Requester -> ctrl : start, a, b
//                Datapath  -> ctrl : isZero, borrow
//                Ctrl -> datapath  : raddr1, raddr2, wen, waddr, wdsrc, func,
//                                    constant
//                Ctrl -> requester : busy, done, divzero
//                Modport slave is the controller, master is the environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface div_seq_ctrl_if;
    import div_seq_ctrl_pkg::*;

    logic                start;
    logic [C_DATA_W-1:0] a;
    logic [C_DATA_W-1:0] b;
    logic                isZero;
    logic                borrow;
    logic [C_ADDR_W-1:0] raddr1;
    logic [C_ADDR_W-1:0] raddr2;
    logic                wen;
    logic [C_ADDR_W-1:0] waddr;
    logic                wdsrc;
    logic [C_FUNC_W-1:0] func;
    logic [C_DATA_W-1:0] constant;
    logic                busy;
    logic                done;
    logic                divzero;

    modport slave (
        input  start, a, b, isZero, borrow,
        output raddr1, raddr2, wen, waddr, wdsrc, func, constant,
        output busy, done, divzero
    );

    modport master (
        output start, a, b, isZero, borrow,
        input  raddr1, raddr2, wen, waddr, wdsrc, func, constant,
        input  busy, done, divzero
    );

endinterface : div_seq_ctrl_if
`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq_ctrl
//  Description : Controller for a restoring-style unsigned divider built on a
//                shared register file and ALU. Division is done by repeated
//                subtraction: R1 holds the running remainder, R3 counts how
//                many times R2 was subtracted.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset
//                bus  - div_seq_ctrl_if.slave (request, datapath control,
//                       status)
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rst,
    div_seq_ctrl_if.slave  bus
);

    state_t              r_state;
    state_t              w_next;
    logic [C_DATA_W-1:0] r_a;
    logic [C_DATA_W-1:0] r_b;
    logic                r_done;
    logic                r_divzero;

    logic [C_ADDR_W-1:0] w_raddr1;
    logic [C_ADDR_W-1:0] w_raddr2;
    logic                w_wen;
    logic [C_ADDR_W-1:0] w_waddr;
    logic                w_wdsrc;
    logic [C_FUNC_W-1:0] w_func;
    logic [C_DATA_W-1:0] w_constant;
    logic                w_busy;

    // ------------------------------------------------------------------------
    // State register, operand capture and registered status flags.
    // done/divzero are computed from the next state so they are high exactly
    // while the controller sits in FIN, and low in every other state.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_state <= w_next;
            // Operands are frozen at acceptance; the inputs are don't-care
            // for the rest of the operation.
            if (r_state == S_IDLE && bus.start) begin
                r_a <= bus.a;
                r_b <= bus.b;
            end
            r_done    <= (w_next == S_FIN);
            // FIN is reached from CHKZ only when the divisor was zero.
            r_divzero <= (w_next == S_FIN) && (r_state == S_CHKZ);
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: w_next = bus.start ? S_LDA : S_IDLE;
            S_LDA:  w_next = S_LDB;
            S_LDB:  w_next = S_CLRQ;
            S_CLRQ: w_next = S_LD1;
            S_LD1:  w_next = S_CHKZ;
            // ALU passes R2 through, so isZero flags a zero divisor.
            S_CHKZ: w_next = bus.isZero ? S_FIN : S_CMP;
            // Borrow on R1-R2 means remainder < divisor: quotient complete.
            S_CMP:  w_next = bus.borrow ? S_FIN : S_SUBT;
            S_SUBT: w_next = S_INCQ;
            S_INCQ: w_next = S_CMP;
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode: everything defaults to the IDLE (all-zero) pattern.
    // ------------------------------------------------------------------------
    always_comb begin
        w_raddr1   = C_R0;
        w_raddr2   = C_R0;
        w_wen      = 1'b0;
        w_waddr    = C_R0;
        w_wdsrc    = C_WDSRC_CONST;
        w_func     = C_FUNC_ADD;
        w_constant = '0;
        w_busy     = 1'b1;
        case (r_state)
            S_LDA: begin
                w_wen      = 1'b1;
                w_waddr    = C_R1;
                w_constant = r_a;
            end
            S_LDB: begin
                w_wen      = 1'b1;
                w_waddr    = C_R2;
                w_constant = r_b;
            end
            S_CLRQ: begin
                w_wen      = 1'b1;
                w_waddr    = C_R3;
            end
            S_LD1: begin
                w_wen      = 1'b1;
                w_waddr    = C_R4;
                w_constant = 32'd1;
            end
            S_CHKZ: begin
                w_func     = C_FUNC_PASS;
                w_raddr1   = C_R2;
            end
            S_CMP: begin
                w_func     = C_FUNC_SUB;
                w_raddr1   = C_R1;
                w_raddr2   = C_R2;
            end
            S_SUBT: begin
                w_func     = C_FUNC_SUB;
                w_raddr1   = C_R1;
                w_raddr2   = C_R2;
                w_wen      = 1'b1;
                w_waddr    = C_R1;
                w_wdsrc    = C_WDSRC_ALU;
            end
            S_INCQ: begin
                w_func     = C_FUNC_ADD;
                w_raddr1   = C_R3;
                w_raddr2   = C_R4;
                w_wen      = 1'b1;
                w_waddr    = C_R3;
                w_wdsrc    = C_WDSRC_ALU;
            end
            S_FIN: begin
                // No datapath activity; status flags come from registers.
            end
            default: begin
                // IDLE and any unused encoding: quiet outputs, not busy.
                w_busy     = 1'b0;
            end
        endcase
    end

    assign bus.raddr1   = w_raddr1;
    assign bus.raddr2   = w_raddr2;
    assign bus.wen      = w_wen;
    assign bus.waddr    = w_waddr;
    assign bus.wdsrc    = w_wdsrc;
    assign bus.func     = w_func;
    assign bus.constant = w_constant;
    assign bus.busy     = w_busy;
    assign bus.done     = r_done;
    assign bus.divzero  = r_divzero;

endmodule : div_seq_ctrl
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_seq_ctrl
//  Description : Self-checking bench for div_seq_ctrl. Models the register
//                file and ALU around the controller, predicts quotient,
//                remainder, divzero and completion cycle from plain
//                arithmetic, and checks them through a scoreboard queue.
//                Cycle n is the clock period ending at the n-th edge after
//                the start-accept edge (cycle 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq_ctrl;
    import div_seq_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    div_seq_ctrl_if bus ();

    div_seq_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- datapath environment: register file + ALU -----------
    logic [31:0] rf [16] = '{default: 32'd0};
    logic [31:0] rd1, rd2, alu;

    always_comb begin
        rd1 = rf[bus.raddr1];
        rd2 = rf[bus.raddr2];
        alu = 32'd0;
        case (bus.func)
            4'd0:    alu = rd1 + rd2;
            4'd1:    alu = rd1 - rd2;
            4'd2:    alu = rd1;
            default: alu = 32'd0;
        endcase
    end
    assign bus.isZero = (alu == 32'd0);
    assign bus.borrow = (bus.func == 4'd1) && (rd1 < rd2);

    always @(posedge clk) begin
        if (bus.wen && bus.waddr != 4'd0)
            rf[bus.waddr] <= bus.wdsrc ? alu : bus.constant;
    end

    // ---------------- scoreboard ------------------------------------------
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: division by repeated subtraction takes 3 cycles per
    // quotient unit on top of a fixed 7-cycle overhead; a zero divisor
    // finishes after the zero check at cycle 6.
    function automatic exp_t predict(input logic [31:0] ia, input logic [31:0] ib, input int acc);
        exp_t e;
        e.dz  = (ib == 32'd0);
        e.q   = e.dz ? 32'd0 : ia / ib;
        e.r   = e.dz ? ia : ia % ib;
        e.lat = e.dz ? 6 : 7 + 3 * int'(e.q);
        e.acc = acc;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_done)
                chk("done_single_cycle", {63'd0, bus.done}, 64'd0);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: done=1 with no request outstanding (t=%0t)", $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_cycle", 64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
                    chk("quotient_R3", {32'd0, rf[3]}, {32'd0, mon_e.q});
                    chk("remainder_R1", {32'd0, rf[1]}, {32'd0, mon_e.r});
                    chk("divzero", {63'd0, bus.divzero}, {63'd0, mon_e.dz});
                    chk("busy_in_fin", {63'd0, bus.busy}, 64'd1);
                end
            end
        end
        prev_done <= bus.done && !rst;
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic check_all_zero(input string name);
        chk(name, {11'd0, bus.raddr1, bus.raddr2, bus.wen, bus.waddr, bus.wdsrc,
                   bus.func, bus.constant, bus.busy, bus.done, bus.divzero}, 64'd0);
    endtask

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib);
        @(negedge clk);
        bus.a     = ia;
        bus.b     = ib;
        bus.start = 1'b1;
        sb.push_back(predict(ia, ib, cyc + 1));
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;   // operands must already be captured
        bus.b     = $urandom;
        chk("busy_after_accept", {63'd0, bus.busy}, 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (!bus.busy) ok = 1'b1;
        end
        chk(tag, {63'd0, bus.busy}, 64'd0);
    endtask

    // ---------------- main sequence ---------------------------------------
    initial begin
        bus.start = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle_after_reset");

        // 7/2: q=3, r=1, done cycle 16
        issue(32'd7, 32'd2);
        wait_idle("idle_7_2");
        // 5/7: q=0, done cycle 7
        issue(32'd5, 32'd7);
        wait_idle("idle_5_7");
        // 9/0: divide by zero, done cycle 6
        issue(32'd9, 32'd0);
        wait_idle("idle_9_0");

        // Reset mid-operation: abort 100/3 in cycle 10, no done afterwards
        issue(32'd100, 32'd3);
        repeat (9) @(negedge clk);
        #3 rst = 1'b1;
        #1 check_all_zero("async_reset_outputs");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_all_zero("no_done_after_abort");
        issue(32'd0, 32'd3);
        wait_idle("idle_0_3");

        // 6/3 with operand changes and start re-pulses while busy
        issue(32'd6, 32'd3);
        @(negedge clk);
        bus.a = 32'd1000;
        bus.b = 32'd1;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;               // sampled at edge 4
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1;               // sampled at edge 9
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle("idle_6_3_repulse");

        // start held from FIN into IDLE: ignored in FIN, accepted in IDLE
        issue(32'd20, 32'd6);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                if (bus.done) seen = 1'b1;
            end
            chk("done_seen_20_6", {63'd0, seen}, 64'd1);
        end
        bus.a     = 32'd50;
        bus.b     = 32'd7;
        bus.start = 1'b1;
        @(negedge clk);
        chk("start_ignored_in_fin", {63'd0, bus.busy}, 64'd0);
        sb.push_back(predict(32'd50, 32'd7, cyc + 1));
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle("idle_50_7");

        // Boundaries: full-width operands
        issue(32'hFFFF_FFFF, 32'h1000_0000);
        wait_idle("idle_max_big");
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle("idle_max_max");
        issue(32'hFFFF_FFFE, 32'hFFFF_FFFF);
        wait_idle("idle_below_max");
        issue(32'd0, 32'd0);
        wait_idle("idle_0_0");

        // Randomized operands with bounded quotient
        for (int n = 0; n < 24; n++) begin
            logic [31:0] ra, rb;
            int sel;
            sel = int'($urandom_range(0, 7));
            if (sel == 0) begin
                rb = 32'd0;
                ra = $urandom;
            end else if (sel == 1) begin
                rb = $urandom | 32'h8000_0000;
                ra = $urandom;
            end else begin
                rb = 32'($urandom_range(1, 32'h000F_FFFF));
                ra = rb * 32'($urandom_range(0, 40)) + 32'($urandom_range(0, int'(rb) - 1));
            end
            issue(ra, rb);
            wait_idle($sformatf("idle_rand_%0d", n));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, bench did not complete");
        $fatal(1, "watchdog");
    end

endmodule : tb_div_seq_ctrl
`default_nettype wire
